// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core pipeline stages.
package mips_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SLL = 4'b0010;
    localparam logic [3:0] ALU_SRL = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    // Control half of the ID/EX pipeline register.
    typedef struct packed {
        logic       valid;
        logic [3:0] alucontrol;
        logic       alusrc;
        logic       shift;
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
    } ctrl_t;

    // A bubble is an invalid slot with no side effects and a harmless add.
    localparam ctrl_t CTRL_BUBBLE = '{
        valid:      1'b0,
        alucontrol: ALU_ADD,
        alusrc:     1'b0,
        shift:      1'b0,
        regwrite:   1'b0,
        memtoreg:   1'b0,
        memwrite:   1'b0
    };

endpackage

// File: rtl/fwd_unit.sv
// Forward source select for one EX-stage source register.
module fwd_unit
    import mips_pkg::*;
(
    input  logic [4:0] i_src,
    input  logic       i_exmem_regwrite,
    input  logic [4:0] i_exmem_rd,
    input  logic       i_memwb_regwrite,
    input  logic [4:0] i_memwb_rd,
    output fwd_sel_t   o_sel
);

    // Youngest producer wins; $0 is hard-wired so it is never forwarded.
    always_comb begin
        o_sel = FWD_RF;
        if (i_exmem_regwrite && (i_exmem_rd != 5'd0) && (i_exmem_rd == i_src)) begin
            o_sel = FWD_EXMEM;
        end else if (i_memwb_regwrite && (i_memwb_rd != 5'd0) && (i_memwb_rd == i_src)) begin
            o_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with operand forwarding, ALU operand build and
// load-use stall detection. A stall or flush loads a bubble into EX.
module idex_stage
    import mips_pkg::*;
#(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         id_valid,
    input  logic [n-1:0] id_rd1,
    input  logic [n-1:0] id_rd2,
    input  logic [n-1:0] id_imm,
    input  logic [4:0]   id_shamt,
    input  logic [4:0]   id_rs,
    input  logic [4:0]   id_rt,
    input  logic [4:0]   id_dst,
    input  logic [3:0]   id_alucontrol,
    input  logic         id_alusrc,
    input  logic         id_shift,
    input  logic         id_uses_rt,
    input  logic         id_regwrite,
    input  logic         id_memtoreg,
    input  logic         id_memwrite,
    input  logic         flush,
    input  logic         exmem_regwrite,
    input  logic [4:0]   exmem_rd,
    input  logic [n-1:0] exmem_result,
    input  logic         memwb_regwrite,
    input  logic [4:0]   memwb_rd,
    input  logic [n-1:0] memwb_result,
    output logic [n-1:0] srca,
    output logic [n-1:0] srcb,
    output logic [3:0]   alucontrol,
    output logic         ex_valid,
    output logic [4:0]   ex_writereg,
    output logic         ex_regwrite,
    output logic         ex_memtoreg,
    output logic         ex_memwrite,
    output logic [n-1:0] ex_writedata,
    output logic         stall_req
);

    ctrl_t        r_ctrl;
    logic [n-1:0] r_rd1, r_rd2, r_imm;
    logic [4:0]   r_shamt, r_rs, r_rt, r_dst;

    fwd_sel_t     w_sel_a, w_sel_b;
    logic [n-1:0] w_fwd_a, w_fwd_b;
    logic         w_stall, w_bubble;

    // Load in EX whose destination the decode instruction reads: hold one cycle.
    assign w_stall = r_ctrl.valid && r_ctrl.memtoreg && (r_dst != 5'd0) && id_valid &&
                     ((r_dst == id_rs) || (id_uses_rt && (r_dst == id_rt)));
    assign w_bubble = flush || w_stall;

    // Pipeline register: reset clears, flush/stall inject a bubble, else capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl  <= CTRL_BUBBLE;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_shamt <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_dst   <= '0;
        end else if (w_bubble) begin
            r_ctrl  <= CTRL_BUBBLE;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_shamt <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_dst   <= '0;
        end else begin
            r_ctrl.valid      <= id_valid;
            r_ctrl.alucontrol <= id_alucontrol;
            r_ctrl.alusrc     <= id_alusrc;
            r_ctrl.shift      <= id_shift;
            r_ctrl.regwrite   <= id_regwrite;
            r_ctrl.memtoreg   <= id_memtoreg;
            r_ctrl.memwrite   <= id_memwrite;
            r_rd1             <= id_rd1;
            r_rd2             <= id_rd2;
            r_imm             <= id_imm;
            r_shamt           <= id_shamt;
            r_rs              <= id_rs;
            r_rt              <= id_rt;
            r_dst             <= id_dst;
        end
    end

    fwd_unit u_fwd_a (
        .i_src            (r_rs),
        .i_exmem_regwrite (exmem_regwrite),
        .i_exmem_rd       (exmem_rd),
        .i_memwb_regwrite (memwb_regwrite),
        .i_memwb_rd       (memwb_rd),
        .o_sel            (w_sel_a)
    );

    fwd_unit u_fwd_b (
        .i_src            (r_rt),
        .i_exmem_regwrite (exmem_regwrite),
        .i_exmem_rd       (exmem_rd),
        .i_memwb_regwrite (memwb_regwrite),
        .i_memwb_rd       (memwb_rd),
        .o_sel            (w_sel_b)
    );

    // Forwarded rs/rt values.
    always_comb begin
        w_fwd_a = r_rd1;
        w_fwd_b = r_rd2;
        case (w_sel_a)
            FWD_EXMEM: w_fwd_a = exmem_result;
            FWD_MEMWB: w_fwd_a = memwb_result;
            default:   w_fwd_a = r_rd1;
        endcase
        case (w_sel_b)
            FWD_EXMEM: w_fwd_b = exmem_result;
            FWD_MEMWB: w_fwd_b = memwb_result;
            default:   w_fwd_b = r_rd2;
        endcase
    end

    // ALU operand build; shifts take the rt value and a zero-extended shamt.
    always_comb begin
        srca = w_fwd_a;
        srcb = r_ctrl.alusrc ? r_imm : w_fwd_b;
        if (r_ctrl.shift) begin
            srca = w_fwd_b;
            srcb = {{(n-5){1'b0}}, r_shamt};
        end
    end

    assign alucontrol   = r_ctrl.alucontrol;
    assign ex_valid     = r_ctrl.valid;
    assign ex_writereg  = r_dst;
    assign ex_regwrite  = r_ctrl.valid && r_ctrl.regwrite;
    assign ex_memtoreg  = r_ctrl.valid && r_ctrl.memtoreg;
    assign ex_memwrite  = r_ctrl.valid && r_ctrl.memwrite;
    assign ex_writedata = w_fwd_b;
    assign stall_req    = w_stall;

endmodule

// File: tb/tb_idex_stage.sv
// Scoreboard bench for idex_stage: directed test-plan cases, then random traffic.
module tb_idex_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic [4:0]  id_shamt, id_rs, id_rt, id_dst;
    logic [3:0]  id_alucontrol;
    logic        id_alusrc, id_shift, id_uses_rt;
    logic        id_regwrite, id_memtoreg, id_memwrite;
    logic        flush;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] srca, srcb, ex_writedata;
    logic [3:0]  alucontrol;
    logic        ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite, stall_req;
    logic [4:0]  ex_writereg;

    idex_stage #(.n(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_shamt(id_shamt),
        .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst), .id_alucontrol(id_alucontrol),
        .id_alusrc(id_alusrc), .id_shift(id_shift), .id_uses_rt(id_uses_rt),
        .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite),
        .flush(flush), .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result), .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
        .memwb_result(memwb_result), .srca(srca), .srcb(srcb), .alucontrol(alucontrol),
        .ex_valid(ex_valid), .ex_writereg(ex_writereg), .ex_regwrite(ex_regwrite),
        .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite), .ex_writedata(ex_writedata),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    // Instruction sitting in EX, as the reference model sees it.
    typedef struct {
        bit        bubble;
        bit        valid;
        bit [31:0] rd1, rd2, imm;
        bit [4:0]  shamt, rs, rt, dst;
        bit [3:0]  op;
        bit        alusrc, shift, regwrite, memtoreg, memwrite;
    } slot_t;

    typedef struct {
        bit        full;
        bit [31:0] srca, srcb, wdata;
        bit [3:0]  op;
        bit [4:0]  wreg;
        bit        valid, rw, mtr, mw, stall;
    } exp_t;

    slot_t m;
    exp_t  q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Value a source register holds from the consumer's point of view.
    function automatic bit [31:0] value_of(input bit [4:0] r, input bit [31:0] rf);
        if (r == 5'd0) return rf;
        if (exmem_regwrite && exmem_rd == r) return exmem_result;
        if (memwb_regwrite && memwb_rd == r) return memwb_result;
        return rf;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        bit [31:0] a, b;
        a = value_of(m.rs, m.rd1);
        b = value_of(m.rt, m.rd2);
        e.full  = !m.bubble;
        e.valid = m.valid;
        e.rw    = m.valid && m.regwrite;
        e.mtr   = m.valid && m.memtoreg;
        e.mw    = m.valid && m.memwrite;
        e.op    = m.op;
        e.wreg  = m.dst;
        e.wdata = b;
        if (m.shift) begin
            e.srca = b;
            e.srcb = 32'(m.shamt);
        end else begin
            e.srca = a;
            e.srcb = m.alusrc ? m.imm : b;
        end
        // A load in EX whose result the decode instruction needs.
        e.stall = e.mtr && m.dst != 0 && id_valid &&
                  (m.dst == id_rs || (id_uses_rt && m.dst == id_rt));
        return e;
    endfunction

    // One clock: push the expectation for the current EX slot, then advance the model.
    task automatic cycle();
        exp_t e;
        if (!reset) m = '{default: 0};
        e = predict();
        q.push_back(e);
        @(posedge clk);
        if (!reset) begin
            m = '{default: 0};
        end else if (flush || e.stall) begin
            m = '{default: 0};
            m.bubble = 1'b1;
        end else begin
            m.bubble = 0;          m.valid = id_valid;
            m.rd1 = id_rd1;        m.rd2 = id_rd2;       m.imm = id_imm;
            m.shamt = id_shamt;    m.rs = id_rs;         m.rt = id_rt;
            m.dst = id_dst;        m.op = id_alucontrol; m.alusrc = id_alusrc;
            m.shift = id_shift;    m.regwrite = id_regwrite;
            m.memtoreg = id_memtoreg; m.memwrite = id_memwrite;
        end
    endtask

    task automatic set_nop();
        id_valid = 0; id_rd1 = 0; id_rd2 = 0; id_imm = 0; id_shamt = 0;
        id_rs = 0; id_rt = 0; id_dst = 0; id_alucontrol = 0; id_alusrc = 0;
        id_shift = 0; id_uses_rt = 0; id_regwrite = 0; id_memtoreg = 0; id_memwrite = 0;
        flush = 0; exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
        memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic set_id(input bit [3:0] op, input bit [31:0] rd1, input bit [31:0] rd2,
                          input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] dst,
                          input bit uses_rt, input bit mtr);
        id_valid = 1; id_alucontrol = op; id_rd1 = rd1; id_rd2 = rd2;
        id_rs = rs; id_rt = rt; id_dst = dst; id_uses_rt = uses_rt;
        id_regwrite = 1; id_memtoreg = mtr; id_memwrite = 0;
        id_alusrc = mtr; id_imm = mtr ? 32'h10 : 32'h0; id_shift = 0; id_shamt = 0;
    endtask

    // Monitor: compare DUT outputs against the oldest expectation each cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("ex_valid", ex_valid, e.valid);
                chk("ex_regwrite", ex_regwrite, e.rw);
                chk("ex_memtoreg", ex_memtoreg, e.mtr);
                chk("ex_memwrite", ex_memwrite, e.mw);
                chk("alucontrol", alucontrol, e.op);
                chk("stall_req", stall_req, e.stall);
                if (e.full) begin
                    chk("srca", srca, e.srca);
                    chk("srcb", srcb, e.srcb);
                    chk("ex_writedata", ex_writedata, e.wdata);
                    chk("ex_writereg", ex_writereg, e.wreg);
                end
            end
        end
    end

    initial begin : stimulus
        m = '{default: 0};
        set_nop();
        // Reset state.
        @(negedge clk); cycle();
        @(negedge clk); cycle();
        // Release reset and capture an add.
        @(negedge clk); reset = 1; set_id(4'b0000, 32'd5, 32'd7, 5'd1, 5'd2, 5'd9, 1, 0); cycle();
        // Forward priority on rs=3, re-issued so each variant sees it in EX.
        @(negedge clk); set_nop(); set_id(4'b0001, 32'h11, 32'h22, 5'd3, 5'd4, 5'd5, 1, 0); cycle();
        @(negedge clk); exmem_regwrite = 1; exmem_rd = 3; exmem_result = 32'hAA;
        memwb_regwrite = 1; memwb_rd = 3; memwb_result = 32'hBB; cycle();
        @(negedge clk); exmem_regwrite = 0; cycle();
        @(negedge clk); exmem_regwrite = 1; exmem_rd = 0; memwb_rd = 0; cycle();
        // sll: rt value 1, shamt 4.
        @(negedge clk); set_nop(); set_id(4'b0010, 32'h0, 32'h1, 5'd0, 5'd6, 5'd7, 1, 0);
        id_shift = 1; id_shamt = 5'd4; cycle();
        @(negedge clk); set_nop(); cycle();
        // Load-use: lw $8, then add reading $8 is held in decode for one bubble.
        @(negedge clk); set_id(4'b0000, 32'h100, 32'h0, 5'd1, 5'd0, 5'd8, 0, 1); cycle();
        @(negedge clk); set_nop(); set_id(4'b0000, 32'h3, 32'h4, 5'd8, 5'd2, 5'd10, 1, 0); cycle();
        @(negedge clk); cycle();
        @(negedge clk); set_nop(); memwb_regwrite = 1; memwb_rd = 8; memwb_result = 32'h55; cycle();
        // Flush during a load-use stall: one bubble only.
        @(negedge clk); set_nop(); set_id(4'b0000, 32'h200, 32'h0, 5'd1, 5'd0, 5'd12, 0, 1); cycle();
        @(negedge clk); set_nop(); set_id(4'b0101, 32'h3, 32'h4, 5'd2, 5'd12, 5'd13, 1, 0);
        flush = 1; cycle();
        @(negedge clk); flush = 0; set_nop(); cycle();
        // Asynchronous reset between edges with a live instruction in EX.
        @(negedge clk); set_id(4'b0100, 32'h1234, 32'h5678, 5'd1, 5'd2, 5'd3, 1, 1); id_memwrite = 1; cycle();
        @(negedge clk); set_nop(); #3; reset = 0; #1;
        chk("async srca", srca, 32'h0);
        chk("async srcb", srcb, 32'h0);
        chk("async ex_valid", ex_valid, 32'h0);
        chk("async ex_memtoreg", ex_memtoreg, 32'h0);
        chk("async ex_memwrite", ex_memwrite, 32'h0);
        chk("async alucontrol", alucontrol, 32'h0);
        chk("async ex_writereg", ex_writereg, 32'h0);
        m = '{default: 0};
        @(negedge clk); cycle();
        @(negedge clk); reset = 1; cycle();
        // Random traffic on a small register window to provoke hazards.
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            id_valid       = ($urandom_range(0, 7) != 0);
            id_rd1         = $urandom;
            id_rd2         = $urandom;
            id_imm         = $urandom;
            id_shamt       = 5'($urandom_range(0, 31));
            id_rs          = 5'($urandom_range(0, 3));
            id_rt          = 5'($urandom_range(0, 3));
            id_dst         = 5'($urandom_range(0, 3));
            id_alucontrol  = 4'($urandom_range(0, 5));
            id_alusrc      = 1'($urandom_range(0, 1));
            id_shift       = ($urandom_range(0, 3) == 0);
            id_uses_rt     = 1'($urandom_range(0, 1));
            id_regwrite    = 1'($urandom_range(0, 1));
            id_memtoreg    = ($urandom_range(0, 2) == 0);
            id_memwrite    = ($urandom_range(0, 3) == 0);
            flush          = ($urandom_range(0, 7) == 0);
            exmem_regwrite = 1'($urandom_range(0, 1));
            exmem_rd       = 5'($urandom_range(0, 3));
            exmem_result   = $urandom;
            memwb_regwrite = 1'($urandom_range(0, 1));
            memwb_rd       = 5'($urandom_range(0, 3));
            memwb_result   = $urandom;
            cycle();
        end
        @(negedge clk); set_nop();
        #5;
        chk("scoreboard drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
